// File: rtl/sysid_checker.sv
// Boot-time integrity checker: reads the system ID and timestamp words over
// Avalon-MM and compares them against build-time constants.
module sysid_checker #(
    parameter logic [31:0] EXPECTED_ID        = 32'd0,
    parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1584078928,
    parameter int          READ_LATENCY       = 0,
    parameter int          TIMEOUT_CYCLES     = 256,
    parameter bit          AUTO_START         = 1'b1
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        start,
    output logic        avm_address,
    output logic        avm_read,
    input  logic        avm_waitrequest,
    input  logic [31:0] avm_readdata,
    output logic [31:0] captured_id,
    output logic [31:0] captured_timestamp,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        fail,
    output logic        id_ok,
    output logic        ts_ok,
    output logic        timeout
);

    typedef enum logic [2:0] {
        IDLE,
        REQ_ID,
        WAIT_ID,
        REQ_TS,
        WAIT_TS,
        COMPARE,
        DONE
    } state_t;

    localparam logic [2:0]  LAT      = 3'(READ_LATENCY);
    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t      state;
    logic [15:0] tmo_cnt;
    logic [2:0]  lat_cnt;
    logic        auto_pending;
    logic        read_step;
    logic        in_req;
    logic        ts_phase;

    // read_step marks the cycle in which the current REQ/WAIT state completes
    always_comb begin
        read_step = 1'b0;
        case (state)
            REQ_ID, REQ_TS:   read_step = !avm_waitrequest;
            WAIT_ID, WAIT_TS: read_step = (lat_cnt == LAT);
            default:          read_step = 1'b0;
        endcase
    end

    assign in_req   = (state == REQ_ID) || (state == REQ_TS);
    assign ts_phase = (state == REQ_TS) || (state == WAIT_TS);

    always_ff @(posedge clock) begin
        if (reset) begin
            state              <= IDLE;
            avm_address        <= 1'b0;
            avm_read           <= 1'b0;
            captured_id        <= 32'd0;
            captured_timestamp <= 32'd0;
            busy               <= 1'b0;
            done               <= 1'b0;
            pass               <= 1'b0;
            fail               <= 1'b0;
            id_ok              <= 1'b0;
            ts_ok              <= 1'b0;
            timeout            <= 1'b0;
            tmo_cnt            <= 16'd0;
            lat_cnt            <= 3'd0;
            auto_pending       <= AUTO_START;
        end else begin
            case (state)
                IDLE: begin
                    auto_pending <= 1'b0;
                    if (start || auto_pending) begin
                        state       <= REQ_ID;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b1;
                        tmo_cnt     <= 16'd0;
                    end
                end

                REQ_ID, WAIT_ID, REQ_TS, WAIT_TS: begin
                    tmo_cnt <= tmo_cnt + 16'd1;
                    lat_cnt <= lat_cnt + 3'd1;
                    if (read_step) begin
                        if (in_req && LAT != 3'd0) begin
                            state    <= ts_phase ? WAIT_TS : WAIT_ID;
                            avm_read <= 1'b0;
                            lat_cnt  <= 3'd1;
                        end else if (!ts_phase) begin
                            captured_id <= avm_readdata;
                            state       <= REQ_TS;
                            avm_read    <= 1'b1;
                            avm_address <= 1'b1;
                            tmo_cnt     <= 16'd0;
                        end else begin
                            captured_timestamp <= avm_readdata;
                            state              <= COMPARE;
                            avm_read           <= 1'b0;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        // abandon the read; any data arriving later is never sampled
                        state    <= DONE;
                        avm_read <= 1'b0;
                        busy     <= 1'b0;
                        done     <= 1'b1;
                        timeout  <= 1'b1;
                        fail     <= 1'b1;
                        pass     <= 1'b0;
                        id_ok    <= 1'b0;
                        ts_ok    <= 1'b0;
                    end
                end

                COMPARE: begin
                    id_ok <= (captured_id == EXPECTED_ID);
                    ts_ok <= (captured_timestamp == EXPECTED_TIMESTAMP);
                    pass  <= (captured_id == EXPECTED_ID) &&
                             (captured_timestamp == EXPECTED_TIMESTAMP);
                    fail  <= !((captured_id == EXPECTED_ID) &&
                               (captured_timestamp == EXPECTED_TIMESTAMP));
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= DONE;
                end

                DONE: begin
                    if (start) begin
                        done        <= 1'b0;
                        pass        <= 1'b0;
                        fail        <= 1'b0;
                        id_ok       <= 1'b0;
                        ts_ok       <= 1'b0;
                        timeout     <= 1'b0;
                        state       <= REQ_ID;
                        avm_read    <= 1'b1;
                        avm_address <= 1'b0;
                        busy        <= 1'b1;
                        tmo_cnt     <= 16'd0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sysid_checker.sv
// Bench for sysid_checker: two instances (latency 0 and latency 2) driven by a
// behavioural Avalon slave, with results predicted from read cycle counts.
`timescale 1ns/1ps
module tb_sysid_checker;

    localparam int          TMO     = 16;
    localparam int          LAT0    = 0;
    localparam int          LAT1    = 2;
    localparam int          STUCK   = 1000;
    localparam logic [31:0] EXP_ID0 = 32'd0;
    localparam logic [31:0] EXP_ID1 = 32'hC0DE_0001;
    localparam logic [31:0] EXP_TS  = 32'd1584078928;
    localparam logic [5:0]  F_PASS  = 6'b110110;
    localparam logic [5:0]  F_TSBAD = 6'b101100;
    localparam logic [5:0]  F_TMO   = 6'b101001;

    logic             clock = 1'b0;
    logic             reset = 1'b1;
    logic [1:0]       start = 2'b00;
    logic [1:0]       rd, addr, wr, busy, done, pass, fail, id_ok, ts_ok, tmo;
    logic [1:0][31:0] rdata, cap_id, cap_ts;

    int          stall_id [2];
    int          stall_ts [2];
    logic [31:0] d_id [2];
    logic [31:0] d_ts [2];
    int          req_cyc [2] = '{0, 0};
    logic [31:0] pipe [2][4];
    logic [31:0] junk = 32'hDEAD_BEEF;
    logic        tr_rd [$];
    logic        tr_addr [$];
    int          checks = 0;
    int          errors = 0;

    always #5 clock = ~clock;

    sysid_checker #(.EXPECTED_ID(EXP_ID0), .EXPECTED_TIMESTAMP(EXP_TS), .READ_LATENCY(LAT0),
                    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)) dut0 (
        .clock(clock), .reset(reset), .start(start[0]),
        .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]),
        .avm_readdata(rdata[0]), .captured_id(cap_id[0]), .captured_timestamp(cap_ts[0]),
        .busy(busy[0]), .done(done[0]), .pass(pass[0]), .fail(fail[0]),
        .id_ok(id_ok[0]), .ts_ok(ts_ok[0]), .timeout(tmo[0])
    );

    sysid_checker #(.EXPECTED_ID(EXP_ID1), .EXPECTED_TIMESTAMP(EXP_TS), .READ_LATENCY(LAT1),
                    .TIMEOUT_CYCLES(TMO), .AUTO_START(1'b1)) dut1 (
        .clock(clock), .reset(reset), .start(start[1]),
        .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]),
        .avm_readdata(rdata[1]), .captured_id(cap_id[1]), .captured_timestamp(cap_ts[1]),
        .busy(busy[1]), .done(done[1]), .pass(pass[1]), .fail(fail[1]),
        .id_ok(id_ok[1]), .ts_ok(ts_ok[1]), .timeout(tmo[1])
    );

    function automatic int lat_of(input bit s);
        return s ? LAT1 : LAT0;
    endfunction

    function automatic logic [31:0] exp_id_of(input bit s);
        return s ? EXP_ID1 : EXP_ID0;
    endfunction

    function automatic logic [5:0] flags(input bit s);
        return {done[s], pass[s], fail[s], id_ok[s], ts_ok[s], tmo[s]};
    endfunction

    // Slave: stalls each read for a programmed number of cycles, returns
    // data after the instance's latency and garbage in every other cycle.
    always_comb begin
        logic       cs;
        logic [1:0] pidx;
        wr    = '0;
        rdata = '0;
        cs    = 1'b0;
        pidx  = 2'd0;
        for (int k = 0; k < 2; k++) begin
            cs = k[0];
            pidx = 2'(lat_of(cs) - 1);
            wr[cs] = rd[cs] && (req_cyc[cs] < (addr[cs] ? stall_ts[cs] : stall_id[cs]));
            if (lat_of(cs) == 0)
                rdata[cs] = (rd[cs] && !wr[cs]) ? (addr[cs] ? d_ts[cs] : d_id[cs]) : junk;
            else
                rdata[cs] = pipe[cs][pidx];
        end
    end

    always @(posedge clock) begin
        logic ps;
        ps = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ps = k[0];
            if (rd[ps] && wr[ps]) req_cyc[ps] <= req_cyc[ps] + 1;
            else                  req_cyc[ps] <= 0;
            pipe[ps][3] <= pipe[ps][2];
            pipe[ps][2] <= pipe[ps][1];
            pipe[ps][1] <= pipe[ps][0];
            pipe[ps][0] <= (rd[ps] && !wr[ps]) ? (addr[ps] ? d_ts[ps] : d_id[ps]) : junk;
        end
    end

    always @(negedge clock) junk <= $urandom();

    // Expected done cycle: each read takes stall+1+latency cycles unless that exceeds TMO.
    function automatic void predict(input bit s, input int sid, input int sts,
                                    output int dcyc, output bit t_id, output bit t_ts);
        int n1, n2;
        n1   = sid + 1 + lat_of(s);
        n2   = sts + 1 + lat_of(s);
        t_id = (n1 > TMO);
        t_ts = !t_id && (n2 > TMO);
        if (t_id)      dcyc = TMO + 1;
        else if (t_ts) dcyc = n1 + TMO + 1;
        else           dcyc = n1 + n2 + 2;
    endfunction

    task automatic do_run(input bit s, input int second_at, output int cyc);
        tr_rd.delete();
        tr_addr.delete();
        tr_rd.push_back(1'b0);
        tr_addr.push_back(1'b0);
        cyc = -1;
        @(negedge clock); start[s] = 1'b1;
        @(negedge clock); start[s] = 1'b0;
        for (int k = 1; k < 200; k++) begin
            tr_rd.push_back(rd[s]);
            tr_addr.push_back(addr[s]);
            if (done[s]) begin
                cyc = k;
                break;
            end
            start[s] = (k == second_at);
            @(negedge clock);
        end
        start[s] = 1'b0;
    endtask

    task automatic wait_auto(output int c0, output int c1);
        c0 = -1;
        c1 = -1;
        for (int k = 1; k < 200; k++) begin
            @(negedge clock);
            if (c0 < 0 && done[0]) c0 = k;
            if (c1 < 0 && done[1]) c1 = k;
            if (c0 >= 0 && c1 >= 0) break;
        end
    endtask

    task automatic test_reset;
        bit s;
        reset = 1'b1;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            s = k[0];
            checks++;
            if ({rd[s], addr[s], busy[s], flags(s)} !== 9'd0) begin
                errors++;
                $display("[TB] FAIL reset_outputs[%0d]: got %b expected 0", k, {rd[s], addr[s], busy[s], flags(s)});
            end
            checks++;
            if ({cap_id[s], cap_ts[s]} !== 64'd0) begin
                errors++;
                $display("[TB] FAIL reset_captured[%0d]: got %h expected 0", k, {cap_id[s], cap_ts[s]});
            end
        end
    endtask

    task automatic test_auto_start;
        int c0, c1;
        reset = 1'b0;
        wait_auto(c0, c1);
        checks++;
        if (c0 !== 4) begin errors++; $display("[TB] FAIL auto_done_cycle0: got %0d expected 4", c0); end
        checks++;
        if (c1 !== 8) begin errors++; $display("[TB] FAIL auto_done_cycle1: got %0d expected 8", c1); end
        checks++;
        if ({flags(0), flags(1)} !== {F_PASS, F_PASS}) begin
            errors++; $display("[TB] FAIL auto_flags: got %b expected %b", {flags(0), flags(1)}, {F_PASS, F_PASS});
        end
    endtask

    task automatic test_basic_pass;
        int cyc;
        do_run(1'b0, 0, cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("[TB] FAIL basic_done_cycle: got %0d expected 4", cyc); end
        checks++;
        if ({tr_rd[1], tr_addr[1], tr_rd[2], tr_addr[2], tr_rd[3]} !== 5'b10110) begin
            errors++;
            $display("[TB] FAIL basic_bus_trace: got %b expected 10110", {tr_rd[1], tr_addr[1], tr_rd[2], tr_addr[2], tr_rd[3]});
        end
        checks++;
        if (flags(0) !== F_PASS) begin errors++; $display("[TB] FAIL basic_flags: got %b expected %b", flags(0), F_PASS); end
        checks++;
        if (cap_ts[0] !== EXP_TS) begin errors++; $display("[TB] FAIL basic_cap_ts: got %0d expected %0d", cap_ts[0], EXP_TS); end
    endtask

    task automatic test_ts_mismatch;
        int cyc;
        d_ts[0] = EXP_TS + 32'd1;
        do_run(1'b0, 0, cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("[TB] FAIL tsbad_done_cycle: got %0d expected 4", cyc); end
        checks++;
        if (flags(0) !== F_TSBAD) begin errors++; $display("[TB] FAIL tsbad_flags: got %b expected %b", flags(0), F_TSBAD); end
        checks++;
        if (cap_ts[0] !== EXP_TS + 32'd1) begin errors++; $display("[TB] FAIL tsbad_cap_ts: got %0d expected %0d", cap_ts[0], EXP_TS + 32'd1); end
        d_ts[0] = EXP_TS;
    endtask

    task automatic test_stall;
        int cyc;
        stall_id[0] = 3;
        do_run(1'b0, 0, cyc);
        for (int k = 1; k <= 4; k++) begin
            checks++;
            if ({tr_rd[k], tr_addr[k]} !== 2'b10) begin
                errors++; $display("[TB] FAIL stall_hold cycle %0d: got %b expected 10", k, {tr_rd[k], tr_addr[k]});
            end
        end
        checks++;
        if (cyc !== 7) begin errors++; $display("[TB] FAIL stall_done_cycle: got %0d expected 7", cyc); end
        checks++;
        if (flags(0) !== F_PASS) begin errors++; $display("[TB] FAIL stall_flags: got %b expected %b", flags(0), F_PASS); end
        stall_id[0] = 0;
    endtask

    task automatic test_timeout;
        int cyc, n;
        stall_id[0] = STUCK;
        do_run(1'b0, 0, cyc);
        n = 0;
        for (int k = 1; k < tr_rd.size() && tr_rd[k] === 1'b1; k++) n++;
        checks++;
        if (n !== TMO) begin errors++; $display("[TB] FAIL timeout_read_cycles: got %0d expected %0d", n, TMO); end
        checks++;
        if (cyc !== TMO + 1) begin errors++; $display("[TB] FAIL timeout_done_cycle: got %0d expected %0d", cyc, TMO + 1); end
        checks++;
        if (flags(0) !== F_TMO) begin errors++; $display("[TB] FAIL timeout_flags: got %b expected %b", flags(0), F_TMO); end
        stall_id[0] = 0;
        do_run(1'b0, 0, cyc);
        checks++;
        if (cyc !== 4) begin errors++; $display("[TB] FAIL recover_done_cycle: got %0d expected 4", cyc); end
        checks++;
        if (flags(0) !== F_PASS) begin errors++; $display("[TB] FAIL recover_flags: got %b expected %b", flags(0), F_PASS); end
    endtask

    task automatic test_latency_ignored;
        int cyc;
        do_run(1'b1, 2, cyc);
        checks++;
        if (cyc !== 8) begin errors++; $display("[TB] FAIL lat2_done_cycle: got %0d expected 8", cyc); end
        checks++;
        if (flags(1) !== F_PASS) begin errors++; $display("[TB] FAIL lat2_flags: got %b expected %b", flags(1), F_PASS); end
        checks++;
        if ({cap_id[1], cap_ts[1]} !== {EXP_ID1, EXP_TS}) begin
            errors++; $display("[TB] FAIL lat2_captured: got %h expected %h", {cap_id[1], cap_ts[1]}, {EXP_ID1, EXP_TS});
        end
        @(negedge clock);
        checks++;
        if (flags(1) !== F_PASS) begin errors++; $display("[TB] FAIL lat2_done_held: got %b expected %b", flags(1), F_PASS); end
    endtask

    task automatic test_reset_mid_op;
        int c0, c1;
        bit s;
        @(negedge clock); start[1] = 1'b1;
        @(negedge clock); start[1] = 1'b0;
        repeat (4) @(negedge clock);
        checks++;
        if ({cap_id[1], rd[1], busy[1]} !== {EXP_ID1, 2'b01}) begin
            errors++; $display("[TB] FAIL midop_wait_ts: got %h expected %h", {cap_id[1], rd[1], busy[1]}, {EXP_ID1, 2'b01});
        end
        reset = 1'b1;
        @(negedge clock);
        for (int k = 0; k < 2; k++) begin
            s = k[0];
            checks++;
            if ({rd[s], addr[s], busy[s], flags(s), cap_id[s], cap_ts[s]} !== 73'd0) begin
                errors++;
                $display("[TB] FAIL midop_reset[%0d]: got %h expected 0", k, {rd[s], addr[s], busy[s], flags(s), cap_id[s], cap_ts[s]});
            end
        end
        reset = 1'b0;
        wait_auto(c0, c1);
        checks++;
        if ({c0, c1} !== {32'd4, 32'd8}) begin errors++; $display("[TB] FAIL midop_rerun_cycles: got %0d/%0d expected 4/8", c0, c1); end
        checks++;
        if (flags(1) !== F_PASS) begin errors++; $display("[TB] FAIL midop_rerun_flags: got %b expected %b", flags(1), F_PASS); end
    endtask

    task automatic test_random;
        int          cyc, ecyc;
        bit          t_id, t_ts, ok_id, ok_ts, s;
        logic [5:0]  ef;
        logic [31:0] m_id [2];
        logic [31:0] m_ts [2];
        m_id[0] = EXP_ID0; m_ts[0] = EXP_TS;
        m_id[1] = EXP_ID1; m_ts[1] = EXP_TS;
        for (int it = 0; it < 24; it++) begin
            s = it[0];
            case ($urandom_range(7))
                0: begin stall_id[s] = STUCK; stall_ts[s] = 0; end
                1: begin stall_id[s] = $urandom_range(5); stall_ts[s] = STUCK; end
                default: begin stall_id[s] = $urandom_range(5); stall_ts[s] = $urandom_range(5); end
            endcase
            d_id[s] = ($urandom_range(3) == 0) ? $urandom() : exp_id_of(s);
            d_ts[s] = ($urandom_range(3) == 0) ? $urandom() : EXP_TS;
            predict(s, stall_id[s], stall_ts[s], ecyc, t_id, t_ts);
            do_run(s, 0, cyc);
            if (!t_id) m_id[s] = d_id[s];
            if (!t_id && !t_ts) m_ts[s] = d_ts[s];
            ok_id = (d_id[s] == exp_id_of(s));
            ok_ts = (d_ts[s] == EXP_TS);
            ef = (t_id || t_ts) ? F_TMO : {1'b1, ok_id && ok_ts, !(ok_id && ok_ts), ok_id, ok_ts, 1'b0};
            checks++;
            if (cyc !== ecyc) begin errors++; $display("[TB] FAIL rand_done_cycle it %0d: got %0d expected %0d", it, cyc, ecyc); end
            checks++;
            if (flags(s) !== ef) begin errors++; $display("[TB] FAIL rand_flags it %0d: got %b expected %b", it, flags(s), ef); end
            checks++;
            if ({cap_id[s], cap_ts[s]} !== {m_id[s], m_ts[s]}) begin
                errors++; $display("[TB] FAIL rand_captured it %0d: got %h expected %h", it, {cap_id[s], cap_ts[s]}, {m_id[s], m_ts[s]});
            end
        end
        stall_id = '{0, 0};
        stall_ts = '{0, 0};
    endtask

    initial begin
        stall_id = '{0, 0};
        stall_ts = '{0, 0};
        d_id[0]  = EXP_ID0;
        d_id[1]  = EXP_ID1;
        d_ts[0]  = EXP_TS;
        d_ts[1]  = EXP_TS;
        test_reset();
        test_auto_start();
        test_basic_pass();
        test_ts_mismatch();
        test_stall();
        test_timeout();
        test_latency_ignored();
        test_reset_mid_op();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
